// File: rtl/uart_matrix_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_matrix_rx
//  Purpose  : 16x-oversampled UART receiver. It recovers 8N1 bytes, LSB first,
//             and presents each one in a one-entry valid/ready buffer. Framing
//             and overrun errors are reported as single-cycle pulses.
//  Options  : UART_RX_PARITY_EN - when defined, the frame is 8E1 and the
//             rx_parity_err pulse output is added.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_matrix_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       uart_rx_rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       uart_rx_work
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_BREAK  = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sync1, r_sync2;
  logic [DW-1:0]   r_div_cnt;
  logic [3:0]      r_tick_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_s7, r_s8;
  logic            r_commit;
  logic            r_frame_err;
  logic            r_overrun;
  logic            r_work;
  logic [7:0]      r_data;
  logic            r_valid;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
  logic            r_parity_err;
`endif

  logic w_rx, w_tick, w_mid, w_end, w_maj;

  assign w_rx   = r_sync2;
  // The divider sits at zero in IDLE, so the first tick of a frame lands on
  // the first START cycle and all later ticks stay phase-aligned to the edge.
  assign w_tick = (r_state != S_IDLE) && (r_div_cnt == '0);
  assign w_mid  = w_tick && (r_tick_cnt == 4'd9);
  assign w_end  = w_tick && (r_tick_cnt == 4'd15);
  // Majority vote over the samples at ticks 7 and 8 and the live value at tick 9
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

  // Two-flop synchronizer; idle-high reset avoids a false start after reset
  always_ff @(posedge clk or negedge uart_rx_rst_n) begin
    if (!uart_rx_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Oversample tick divider, held at zero while idle
  always_ff @(posedge clk or negedge uart_rx_rst_n) begin
    if (!uart_rx_rst_n) begin
      r_div_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Receive FSM: bit timing, sampling, shifting and the stop-bit decision
  always_ff @(posedge clk or negedge uart_rx_rst_n) begin
    if (!uart_rx_rst_n) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_commit    <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if (r_tick_cnt == 4'd7) r_s7 <= w_rx;
        if (r_tick_cnt == 4'd8) r_s8 <= w_rx;
      end
      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= 4'd0;
          if (!w_rx) r_state <= S_START;
        end
        S_START: begin
          // A start bit that reads high at mid-bit is a glitch, not a frame
          if (w_mid && w_maj) begin
            r_state <= S_IDLE;
          end else if (w_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_mid) r_shift <= {w_maj, r_shift[7:1]};
          if (w_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_mid) r_par_bad <= w_maj ^ (^r_shift);
          if (w_end) r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Decide at mid stop bit so the next start edge is never missed
          if (w_mid) begin
            if (w_maj) begin
              r_commit <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-entry output buffer with overrun detection
  always_ff @(posedge clk or negedge uart_rx_rst_n) begin
    if (!uart_rx_rst_n) begin
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_commit) begin
`ifdef UART_RX_PARITY_EN
        r_parity_err <= r_par_bad;
`endif
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Busy flag, one cycle behind the FSM leaving and re-entering IDLE
  always_ff @(posedge clk or negedge uart_rx_rst_n) begin
    if (!uart_rx_rst_n) r_work <= 1'b0;
    else                r_work <= (r_state != S_IDLE);
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;
  assign uart_rx_work = r_work;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: doc/uart_matrix_rx.md
Name: uart_matrix_rx

Overview:
UART receiver, the receive-side counterpart of the matrix-data UART transmitter in `top`. Samples the asynchronous serial line at 16x oversampling and recovers 8N1 bytes, LSB first. Presents each byte on a one-entry valid/ready output buffer for the downstream matrix assembler. Reports framing and overrun errors as single-cycle pulses.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate.
OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.

Ports:
clk  input  1  system clock, rising edge.
uart_rx_rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
uart_rx  input  1  serial line; idle high; asynchronous to clk.
rx_data  output  8  received byte; stable while rx_valid=1.
rx_valid  output  1  byte available in the output buffer.
rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready at a clk edge.
rx_frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
rx_overrun  output  1  one-cycle pulse: byte completed while the buffer was full and not being drained.
uart_rx_work  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=0x00, rx_valid=0, rx_frame_err=0, rx_overrun=0, uart_rx_work=0, FSM=IDLE. Synchronizer flops reset to 1.
- Reset asserted mid-frame aborts the frame immediately. Partial data is discarded, and a buffered byte is lost.
- Input synchronizer: 2-flop chain on uart_rx, giving 2 cycles of latency. All logic uses the synchronized value.
- Tick generator: divisor DIV = CLK_FREQ/(BAUD_RATE*16), integer-truncated (54 at the defaults). Counter reloads on the IDLE->START transition, so ticks are phase-aligned to the start edge. The counter is held in IDLE.
- Bit tick counter runs 0..15 per bit. Each bit is sampled as the majority of synchronized values at ticks 7, 8 and 9, and the decision is taken at tick 9.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: synchronized line low -> START.
  - START: majority at ticks 7-9 is 1 -> glitch, go to IDLE with no error. Majority is 0 -> continue to tick 15, then DATA with bit index 0.
  - DATA: shift in 8 bits LSB first, 16 ticks each. After bit 7 -> STOP.
  - STOP: decision at tick 9 (mid-bit, not end of bit, to allow resync).
    - Sample 1 -> commit the byte, then IDLE.
    - Sample 0 -> rx_frame_err pulse, byte discarded, then BREAK.
  - BREAK: wait until the synchronized line is 1, then IDLE.
- Commit timing: rx_valid rises the clock after the stop decision, with rx_data updated in the same edge.
- Output buffer rules:
  - rx_valid && rx_ready clears rx_valid, unless a commit happens in the same cycle.
  - Commit while rx_valid=1 and rx_ready=1 in the same cycle: the new byte loads and rx_valid stays 1.
  - Commit while rx_valid=1 and rx_ready=0: the new byte is dropped, the old byte is kept, and rx_overrun pulses for 1 cycle.
- rx_ready while rx_valid=0 is ignored.
- uart_rx_work is registered; it is high from the cycle after leaving IDLE until the cycle after returning to IDLE.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: frame becomes 8E1. A PARITY state sits between DATA and STOP, sampled like the data bits. Adds output port rx_parity_err, a 1-bit, one-cycle pulse raised at the stop commit when even parity fails. The byte is still committed, so the consumer decides whether to use it.
- Undefined: no PARITY state, no rx_parity_err port, 8N1 only.

Test Plan:
Defaults apply: 100 MHz clk, bit time 864 clocks, rx_ready=1 unless stated.
1. Send 0xA5, 8N1 -> one rx_valid pulse with rx_data=0xA5. rx_valid rises about 9.5 bit times after the start edge; rx_frame_err=0, uart_rx_work returns to 0.
2. Low glitch of 200 clocks on an idle line -> no rx_valid, no error. uart_rx_work high for under 500 cycles, then 0.
3. Send 0x3C with the stop bit forced to 0, line held low 2 extra bit times -> rx_frame_err pulse, no rx_valid. The next frame, 0x81, is received correctly.
4. rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_data stays 0x11 with rx_valid held, and rx_overrun pulses once at the 0x22 commit. Then raise rx_ready for 1 cycle -> rx_valid=0.
5. Assert uart_rx_rst_n=0 mid-data of byte 0x77, release, then send 0x5A -> all outputs 0 during reset, no 0x77 delivered, 0x5A received correctly.
6. UART_RX_PARITY_EN defined: send 0x03 with parity 1, which is wrong -> rx_data=0x03, rx_valid=1, rx_parity_err pulse. Send 0x03 with parity 0 -> no rx_parity_err.
